// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: scancodes, frame FSM states and the
// odd-parity helper used by the receiver.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // True when data plus parity hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, frame FSM
// with inter-edge timeout; emits validated bytes and error strobes.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]            clk_sync_r;
    logic [1:0]            data_sync_r;
    logic [FILTER_LEN-1:0] filt_r;
    logic                  fclk_r;
    logic                  fall_s;
    logic                  din_s;
    rx_state_e             state_r;
    rx_state_e             state_nx_s;
    logic [2:0]            bit_cnt_r;
    logic [7:0]            shift_r;
    logic                  par_r;
    logic [TW-1:0]         to_cnt_r;
    logic                  timeout_s;
    logic                  frame_ok_s;
    logic                  valid_s;
    logic                  err_s;
    logic [7:0]            scan_code_r;
    logic                  scan_valid_r;
    logic                  frame_err_r;

    assign din_s      = data_sync_r[1];
    // Falling edge is flagged on the cycle the filter sees a full run of zeros.
    assign fall_s     = fclk_r & ~(|filt_r);
    assign timeout_s  = (state_r != ST_IDLE) && (to_cnt_r == TO_MAX);
    assign frame_ok_s = odd_parity_ok(shift_r, par_r) & din_s;

    // Two-flop synchronisers and the clock glitch filter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
            filt_r      <= '1;
            fclk_r      <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
            filt_r      <= {filt_r[FILTER_LEN-2:0], clk_sync_r[1]};
            if (&filt_r) begin
                fclk_r <= 1'b1;
            end else if (~|filt_r) begin
                fclk_r <= 1'b0;
            end else begin
                fclk_r <= fclk_r;
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame FSM next-state logic; timeout overrides everything.
    always_comb begin
        state_nx_s = state_r;
        if (timeout_s) begin
            state_nx_s = ST_IDLE;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE:   state_nx_s = din_s ? ST_IDLE : ST_DATA;
                ST_DATA:   state_nx_s = (bit_cnt_r == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_nx_s = ST_STOP;
                ST_STOP:   state_nx_s = ST_IDLE;
                default:   state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Frame FSM strobe decode (registered below).
    always_comb begin
        valid_s = 1'b0;
        err_s   = 1'b0;
        if (timeout_s) begin
            err_s = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE: err_s = din_s;
                ST_STOP: begin
                    valid_s = frame_ok_s;
                    err_s   = ~frame_ok_s;
                end
                default: begin
                    valid_s = 1'b0;
                    err_s   = 1'b0;
                end
            endcase
        end else begin
            valid_s = 1'b0;
            err_s   = 1'b0;
        end
    end

    // Bit counter, shift register, parity capture and saturating timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            to_cnt_r  <= '0;
        end else if (timeout_s) begin
            bit_cnt_r <= 3'd0;
            to_cnt_r  <= '0;
        end else begin
            if (fall_s || (state_r == ST_IDLE)) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_MAX) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (fall_s) begin
                case (state_r)
                    ST_IDLE:   bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {din_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r <= din_s;
                    default:   bit_cnt_r <= 3'd0;
                endcase
            end
        end
    end

    // Registered receiver outputs; scan_code only moves on a good frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_code_r  <= 8'h00;
            scan_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            scan_valid_r <= valid_s;
            frame_err_r  <= err_s;
            if (valid_s) begin
                scan_code_r <= shift_r;
            end
        end
    end

    assign scan_code  = scan_code_r;
    assign scan_valid = scan_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns PS/2 make/break scancodes into held movement levels for the draw
// stage; WASD and the extended arrow keys share each direction.
module ps2_move_decoder
    import kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       move_up,
    output logic       move_down,
    output logic       move_right,
    output logic       move_left,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    // held bit order: W S D A Up Down Right Left
    logic [7:0] held_r;
    logic [7:0] held_nx_s;
    logic       ext_r;
    logic       ext_nx_s;
    logic       brk_r;
    logic       brk_nx_s;
    logic [7:0] rx_code_s;
    logic       rx_valid_s;
    logic       rx_err_s;
    logic       move_up_r;
    logic       move_down_r;
    logic       move_right_r;
    logic       move_left_r;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (rx_code_s),
        .scan_valid (rx_valid_s),
        .frame_err  (rx_err_s)
    );

    // Prefix tracking and key-map decode of each received byte.
    always_comb begin
        held_nx_s = held_r;
        ext_nx_s  = ext_r;
        brk_nx_s  = brk_r;
        if (rx_valid_s) begin
            if (rx_code_s == SC_EXT) begin
                ext_nx_s = 1'b1;
            end else if (rx_code_s == SC_BRK) begin
                brk_nx_s = 1'b1;
            end else begin
                case ({ext_r, rx_code_s})
                    {1'b0, SC_W}:     held_nx_s[0] = ~brk_r;
                    {1'b0, SC_S}:     held_nx_s[1] = ~brk_r;
                    {1'b0, SC_D}:     held_nx_s[2] = ~brk_r;
                    {1'b0, SC_A}:     held_nx_s[3] = ~brk_r;
                    {1'b1, SC_UP}:    held_nx_s[4] = ~brk_r;
                    {1'b1, SC_DOWN}:  held_nx_s[5] = ~brk_r;
                    {1'b1, SC_RIGHT}: held_nx_s[6] = ~brk_r;
                    {1'b1, SC_LEFT}:  held_nx_s[7] = ~brk_r;
                    default:          held_nx_s = held_r;
                endcase
                ext_nx_s = 1'b0;
                brk_nx_s = 1'b0;
            end
        end else begin
            held_nx_s = held_r;
        end
    end

    // Key state and movement outputs; moves follow the deciding byte by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_r       <= 8'h00;
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            move_up_r    <= 1'b0;
            move_down_r  <= 1'b0;
            move_right_r <= 1'b0;
            move_left_r  <= 1'b0;
        end else begin
            held_r       <= held_nx_s;
            ext_r        <= ext_nx_s;
            brk_r        <= brk_nx_s;
            move_up_r    <= held_nx_s[0] | held_nx_s[4];
            move_down_r  <= held_nx_s[1] | held_nx_s[5];
            move_right_r <= held_nx_s[2] | held_nx_s[6];
            move_left_r  <= held_nx_s[3] | held_nx_s[7];
        end
    end

    assign move_up    = move_up_r;
    assign move_down  = move_down_r;
    assign move_right = move_right_r;
    assign move_left  = move_left_r;
    assign scan_code  = rx_code_s;
    assign scan_valid = rx_valid_s;
    assign frame_err  = rx_err_s;

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Receives PS/2 keyboard frames and decodes make/break scancodes into held movement levels `move_up`, `move_down`, `move_right`, `move_left`.
- Those four levels drive the player-movement inputs of the rectangle/point draw stage.
- Sits at the input boundary: PS/2 pins in, game-control levels out, all in the pixel clock domain.
- Also exposes raw scancode strobes and a frame-error strobe for debug and future keys.

Parameters:
- `FILTER_LEN`, 8: consecutive equal `ps2_clk` samples required to change the filtered clock level.
- `TIMEOUT_CYCLES`, 65000: clk cycles without a filtered falling edge that abort a frame in progress (about 1 ms at 65 MHz).

Ports:
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock from pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from pin, asynchronous.
- `move_up`  out  1  level, high while W or Up-arrow is held.
- `move_down`  out  1  level, high while S or Down-arrow is held.
- `move_right`  out  1  level, high while D or Right-arrow is held.
- `move_left`  out  1  level, high while A or Left-arrow is held.
- `scan_code`  out  8  last correctly received byte.
- `scan_valid`  out  1  one-cycle strobe; `scan_code` is new.
- `frame_err`  out  1  one-cycle strobe on parity, stop, start or timeout error.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - All outputs 0 and `scan_code`=0.
  - FSM goes to IDLE; bit and timeout counters cleared.
  - Filter shift register set to all ones; filtered clock = 1.
  - Synchronisers set to 1; prefix flags cleared; all 8 key-held bits cleared.
- Synchronisation and filtering:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - The synchronised clock shifts into a `FILTER_LEN`-bit register. Filtered clock goes 0 when all bits are 0, goes 1 when all bits are 1, otherwise holds.
  - A falling edge is the filtered clock going 1->0; on that cycle the synchronised data is sampled.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge with data=0, go to DATA with bit_cnt=0. With data=1, pulse `frame_err` and stay in IDLE.
  - DATA: on each falling edge, shift data in LSB-first. After bit 7 go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on a falling edge, check that data bits plus parity bit contain an odd number of ones, and that stop=1.
    - Both correct: in the next cycle `scan_valid`=1 and `scan_code`=byte.
    - Either wrong: in the next cycle `frame_err`=1 and `scan_code` is unchanged.
  - STOP always returns to IDLE.
  - Timeout counter clears on every falling edge and counts only outside IDLE. Reaching `TIMEOUT_CYCLES` forces IDLE, clears bit_cnt and pulses `frame_err` once.
- Decoder, acting on cycles with `scan_valid`=1:
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Neither changes key state.
  - Any other byte:
    - If it matches the key map, set that key's held bit to `!brk`.
    - Then clear both `ext` and `brk`, whether or not it matched.
  - Key map:
    - ext=0: 0x1D W, 0x1B S, 0x23 D, 0x1C A.
    - ext=1: 0x75 Up, 0x72 Down, 0x74 Right, 0x6B Left.
  - Non-extended 0x75/0x72/0x74/0x6B are keypad keys and are ignored. Extended 0x1D/0x1B/0x23/0x1C are ignored.
  - 0xAA, 0xFF, 0xE1 and unmapped codes only clear the flags.
- Outputs:
  - `move_*` are registered ORs of the two held bits per direction. They change one cycle after the `scan_valid` of the deciding byte.
  - Opposite directions may both be high; arbitration belongs to the consumer.
- Width rules: bit_cnt is 3 bits; the timeout counter is $clog2(`TIMEOUT_CYCLES`+1) bits and saturates.

Decomposition:
- `kbd_pkg` holds:
  - Scancode constants: `SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_W`, `SC_A`, `SC_S`, `SC_D`, `SC_UP`, `SC_DOWN`, `SC_RIGHT`, `SC_LEFT`.
  - The FSM state enum type.
- Sub-module `ps2_rx`: synchronisers, filter, frame FSM and timeout. Outputs `scan_code`, `scan_valid`, `frame_err`.
- `ps2_move_decoder` instantiates `ps2_rx` and holds the prefix flags and the key-held register.

Test Plan:
- Bench PS/2 bit period 100 us, clk 65 MHz.
- Frame 0x1D, parity 1 -> exactly one `scan_valid` with `scan_code`=0x1D; `move_up`=1 one cycle later; `frame_err` stays 0.
- Bytes F0,1D -> two `scan_valid` pulses; `move_up` returns to 0 after the second; other `move_*` stay 0.
- Held-key overlap:
  - Send E0,75 -> `move_up`=1.
  - Send 1D -> `move_up` stays 1.
  - Send F0,1D -> `move_up` still 1.
  - Send E0,F0,75 -> `move_up`=0.
- Frame 0x1C with parity 1 (wrong) -> one `frame_err` pulse, no `scan_valid`, `move_left`=0, `scan_code` unchanged.
- Timeout then recovery:
  - Send start + 3 data bits, then idle `ps2_clk` high for 1.1 ms -> one `frame_err` pulse, FSM back in IDLE.
  - Then send frame 0x23, parity 0 -> `move_right`=1.
- Robustness:
  - 3-cycle low glitch on `ps2_clk` -> no bit sampled, nothing emitted.
  - `rst`=0 asserted mid-DATA while `move_left`=1 -> all outputs 0 immediately, without waiting for a clock edge.
  - After release, frame 0x1C -> `move_left`=1.
